aqms_top: RTL and testbench
===========================

Name: aqms_top

Overview:
- Reduced top level of the Aquarius+ SMS-compatible core. It generates the Z80 clock (ebus_phi) from sysclk.
- It decodes Z80 I/O cycles to the VDP data and control ports. It holds the VDP register file, VRAM, CRAM (palette) and frame timing.
- It drives the open-drain frame interrupt line.
- Video, audio, ESP32 and hand-controller paths are out of scope; their pins are tied inactive.

Parameters:
- PHI_DIV, 8: sysclk cycles per ebus_phi period (28.636 MHz / 8 = 3.58 MHz).
- LINE_CYCLES, 228: phi cycles per scanline.
- TOTAL_LINES, 262: lines per frame.
- ACTIVE_LINES, 192: the vblank flag sets at the start of this line.

Ports:
- sysclk  in  1  system clock, ~28.636 MHz; all logic runs on it.
- ebus_reset_n  in  1  reset; synchronous, active-low.
- ebus_phi  out  1  Z80 clock; 50% duty.
- ebus_a  in  16  Z80 address.
- ebus_d  inout  8  Z80 data; driven only during a decoded VDP read.
- ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n  in  1 each  Z80 strobes, active-low.
- ebus_int_n  out  1  open-drain interrupt: drives 0, otherwise Z.
- ebus_busreq_n  out  1  always Z (open-drain, never asserted).
- ebus_busack_n  in  1  when low, all bus inputs are ignored.

Behaviour:
- Reset, while ebus_reset_n=0 at a sysclk edge:
  - phi divider=0, so ebus_phi=0.
  - All VDP registers=0.
  - addr=0, code=0, first-byte latch clear, read buffer=0.
  - Status=0; frame counters=0.
  - ebus_int_n=Z; ebus_d=Z.
  - VRAM/CRAM contents are undefined.
- phi: ebus_phi toggles every PHI_DIV/2 sysclk cycles. One phi tick = the sysclk cycle where ebus_phi rises.
- Bus sync: rd_n, wr_n and iorq_n pass through 2-flop synchronizers.
- Port decode: io_sel = iorq_n=0, mreq_n=1, A[7:6]=2'b10, busack_n=1.
  - A[0]=0 is the data port (0xBE).
  - A[0]=1 is the control port (0xBF).
  - Memory cycles are ignored.
- Write event: one sysclk pulse on the synchronized falling edge of (iorq_n|wr_n) while decoded. ebus_d and ebus_a are sampled at that edge; they are stable by then.
- Control write, first byte: latch the byte into addr[7:0] and set the first-byte flag.
- Control write, second byte: addr[13:8]=d[5:0], code=d[7:6], clear the flag. Then, by code:
  - 00: prefetch VRAM[addr] into the read buffer, addr+=1.
  - 10: reg[d[3:0]] = first byte. Indices above 10 are ignored.
  - 01 and 11: no further action.
- Data write:
  - code=11: CRAM[addr[4:0]]=d[5:0].
  - Otherwise: VRAM[addr]=d.
  - Then addr+=1, wrapping at 14 bits (0x3FFF→0x0000). Clear the first-byte flag.
- Read (decoded iorq_n=0, rd_n=0): ebus_d is driven combinationally from pins, so data is valid within the Z80 T2/T3 window.
  - Control port returns status {vblank, 1'b0, 1'b0, 5'b0}.
  - Data port returns the read buffer.
- Read side effect: applied once, on the synchronized rising edge of (iorq_n|rd_n).
  - Control read: clear vblank and clear the first-byte flag.
  - Data read: read buffer = VRAM[addr], addr+=1, clear the first-byte flag.
- Frame timing:
  - Pixel counter counts phi ticks, 0..LINE_CYCLES-1.
  - Line counter counts 0..TOTAL_LINES-1, then wraps.
  - At line ACTIVE_LINES, pixel 0: vblank=1.
- Simultaneous set and clear: if the vblank set and a status-read clear land in the same sysclk cycle, the set wins.
- Interrupt: ebus_int_n=0 while vblank=1 && reg1[5]=1, otherwise Z. Clearing reg1[5] releases the line immediately; vblank stays set.
- Reset mid-access: any pending half-written control word is discarded.

Test Plan:
- Reset, then control read at 0xBF → ebus_d=0x00 during the strobe; ebus_int_n=Z.
- Write 0x00, 0xC0 to 0xBF, then 0x01..0x07 to 0xBE → CRAM[0..6]=0x01..0x07; addr=7.
- Write 0x20, 0x81 to 0xBF → reg1=0x20. With LINE_CYCLES=8, TOTAL_LINES=4, ACTIVE_LINES=2: ebus_int_n=0 at line 2, pixel 0.
- With interrupt asserted, read 0xBF → returns 0x80; ebus_int_n=Z after the strobe ends; a second read returns 0x00.
- Write 0xFF, 0x7F to 0xBF, then 0xAA and 0x55 to 0xBE → VRAM[0x3FFF]=0xAA, VRAM[0x0000]=0x55 (address wrap).
- Set addr 0x0000 with code 00, then read 0xBE twice → returns 0x55, then VRAM[0x0001]. A single control byte followed by a status read → the latch resets, so the next byte is treated as a first byte.

Source files
------------

// File: rtl/aqms_top.sv
// Reduced Aquarius+ SMS core top: Z80 clock generation, VDP port decode,
// register file, VRAM/CRAM, frame timing and the open-drain frame interrupt.
module aqms_top #(
    parameter int PHI_DIV      = 8,
    parameter int LINE_CYCLES  = 228,
    parameter int TOTAL_LINES  = 262,
    parameter int ACTIVE_LINES = 192
) (
    input  logic        sysclk,
    input  logic        ebus_reset_n,
    output logic        ebus_phi,
    input  logic [15:0] ebus_a,
    inout  logic [7:0]  ebus_d,
    input  logic        ebus_rd_n,
    input  logic        ebus_wr_n,
    input  logic        ebus_mreq_n,
    input  logic        ebus_iorq_n,
    output logic        ebus_int_n,
    output logic        ebus_busreq_n,
    input  logic        ebus_busack_n
);
    localparam int HALF = PHI_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PW   = $clog2(LINE_CYCLES);
    localparam int LW   = $clog2(TOTAL_LINES);

    logic [DW-1:0]      div;
    logic               phi;
    logic               phi_tick;
    logic [1:0]         rd_sync, wr_sync, iorq_sync;
    logic               wr_strb, rd_strb, wr_strb_q, rd_strb_q;
    logic               dec, wr_evt, rd_evt, rd_act;
    logic               rd_pend, rd_port;
    logic [7:0]         din;
    logic [10:0][7:0]   regs;
    logic [31:0][5:0]   cram;
    logic [7:0]         vram [0:16383];
    logic [13:0]        addr;
    logic [1:0]         code;
    logic               first;
    logic [7:0]         rbuf;
    logic               vblank, vb_set;
    logic [PW-1:0]      pix_cnt;
    logic [LW-1:0]      line_cnt;
    logic               unused;

    assign phi_tick = (div == DW'(HALF - 1)) && !phi;
    assign ebus_phi = phi;

    always_ff @(posedge sysclk) begin
        if (!ebus_reset_n) begin
            div <= '0;
            phi <= 1'b0;
        end else if (div == DW'(HALF - 1)) begin
            div <= '0;
            phi <= ~phi;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Decode uses the raw address pins; they are stable across the synchronized strobe.
    assign dec     = ebus_busack_n && ebus_mreq_n && (ebus_a[7:6] == 2'b10);
    assign wr_strb = iorq_sync[1] | wr_sync[1];
    assign rd_strb = iorq_sync[1] | rd_sync[1];
    assign wr_evt  = wr_strb_q && !wr_strb && dec;
    assign rd_evt  = rd_strb && !rd_strb_q && rd_pend;
    assign din     = ebus_d;

    assign vb_set = phi_tick && (pix_cnt == PW'(LINE_CYCLES - 1))
                    && (line_cnt == LW'(ACTIVE_LINES - 1));

    always_ff @(posedge sysclk) begin
        if (!ebus_reset_n) begin
            rd_sync   <= '1;
            wr_sync   <= '1;
            iorq_sync <= '1;
            wr_strb_q <= 1'b1;
            rd_strb_q <= 1'b1;
            rd_pend   <= 1'b0;
            rd_port   <= 1'b0;
            regs      <= '0;
            addr      <= '0;
            code      <= '0;
            first     <= 1'b0;
            rbuf      <= '0;
            vblank    <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
        end else begin
            rd_sync   <= {rd_sync[0], ebus_rd_n};
            wr_sync   <= {wr_sync[0], ebus_wr_n};
            iorq_sync <= {iorq_sync[0], ebus_iorq_n};
            wr_strb_q <= wr_strb;
            rd_strb_q <= rd_strb;

            if (phi_tick) begin
                if (pix_cnt == PW'(LINE_CYCLES - 1)) begin
                    pix_cnt  <= '0;
                    line_cnt <= (line_cnt == LW'(TOTAL_LINES - 1)) ? '0 : line_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            // Capture the port while the read is live; the address may move before release.
            if (!rd_strb && dec) begin
                rd_pend <= 1'b1;
                rd_port <= ebus_a[0];
            end else if (rd_evt) begin
                rd_pend <= 1'b0;
            end

            if (vb_set)
                vblank <= 1'b1;
            else if (rd_evt && rd_port)
                vblank <= 1'b0;

            if (wr_evt) begin
                if (ebus_a[0]) begin
                    if (!first) begin
                        addr[7:0] <= din;
                        first     <= 1'b1;
                    end else begin
                        first <= 1'b0;
                        code  <= din[7:6];
                        case (din[7:6])
                            2'b00: begin
                                rbuf <= vram[{din[5:0], addr[7:0]}];
                                addr <= {din[5:0], addr[7:0]} + 14'd1;
                            end
                            2'b10: begin
                                addr <= {din[5:0], addr[7:0]};
                                if (din[3:0] <= 4'd10)
                                    regs[din[3:0]] <= addr[7:0];
                            end
                            default: addr <= {din[5:0], addr[7:0]};
                        endcase
                    end
                end else begin
                    addr  <= addr + 14'd1;
                    first <= 1'b0;
                end
            end else if (rd_evt) begin
                first <= 1'b0;
                if (!rd_port) begin
                    rbuf <= vram[addr];
                    addr <= addr + 14'd1;
                end
            end
        end
    end

    // Memories carry no reset so they can map onto block RAM.
    always_ff @(posedge sysclk) begin
        if (ebus_reset_n && wr_evt && !ebus_a[0]) begin
            if (code == 2'b11)
                cram[addr[4:0]] <= din[5:0];
            else
                vram[addr] <= din;
        end
    end

    assign rd_act        = ebus_reset_n && dec && !ebus_iorq_n && !ebus_rd_n;
    assign ebus_d        = rd_act ? (ebus_a[0] ? {vblank, 7'b0} : rbuf) : 8'hzz;
    assign ebus_int_n    = (vblank && regs[1][5]) ? 1'b0 : 1'bz;
    assign ebus_busreq_n = 1'bz;

    assign unused = ^{ebus_a[15:8], ebus_a[5:1], regs, cram};
endmodule

// File: tb/tb_aqms_top.sv
// Directed bench for aqms_top with a shortened frame (8 phi per line, 4 lines).
module tb_aqms_top;
    logic        sysclk = 1'b0;
    logic        ebus_reset_n;
    wire         ebus_phi;
    logic [15:0] ebus_a;
    wire  [7:0]  ebus_d;
    logic        ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n;
    wire         ebus_int_n;
    wire         ebus_busreq_n;
    logic        ebus_busack_n;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  rdata;
    int          nchk = 0;
    int          nfail = 0;

    assign ebus_d = d_oe ? d_out : 8'hzz;
    pullup (ebus_int_n);

    aqms_top #(.PHI_DIV(8), .LINE_CYCLES(8), .TOTAL_LINES(4), .ACTIVE_LINES(2)) dut (
        .sysclk(sysclk), .ebus_reset_n(ebus_reset_n), .ebus_phi(ebus_phi),
        .ebus_a(ebus_a), .ebus_d(ebus_d), .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n),
        .ebus_mreq_n(ebus_mreq_n), .ebus_iorq_n(ebus_iorq_n), .ebus_int_n(ebus_int_n),
        .ebus_busreq_n(ebus_busreq_n), .ebus_busack_n(ebus_busack_n)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge sysclk);
        ebus_a = a; d_out = d; d_oe = 1'b1; ebus_iorq_n = 1'b0; ebus_wr_n = 1'b0;
        repeat (5) @(negedge sysclk);
        ebus_iorq_n = 1'b1; ebus_wr_n = 1'b1;
        repeat (5) @(negedge sysclk);
        d_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge sysclk);
        ebus_a = a; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0;
        repeat (3) @(negedge sysclk);
        d = ebus_d;
        repeat (2) @(negedge sysclk);
        ebus_iorq_n = 1'b1; ebus_rd_n = 1'b1;
        repeat (5) @(negedge sysclk);
    endtask

    task automatic wait_int_low();
        for (int k = 0; k < 400 && ebus_int_n !== 1'b0; k++) @(negedge sysclk);
    endtask

    initial begin
        ebus_reset_n = 1'b0; ebus_a = 16'h0; ebus_rd_n = 1'b1; ebus_wr_n = 1'b1;
        ebus_mreq_n = 1'b1; ebus_iorq_n = 1'b1; ebus_busack_n = 1'b1;
        d_out = 8'h00; d_oe = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("reset_phi", ebus_phi, 1'b0);
        chk("reset_int", ebus_int_n, 1'b1);
        ebus_reset_n = 1'b1;

        bus_read(16'h00BF, rdata);
        chk("status_after_reset", rdata, 8'h00);
        chk("int_after_reset", ebus_int_n, 1'b1);

        // CRAM writes through code 11
        bus_write(16'h00BF, 8'h00);
        bus_write(16'h00BF, 8'hC0);
        for (int i = 1; i <= 7; i++) bus_write(16'h00BE, 8'(i));
        for (int i = 0; i < 7; i++) chk($sformatf("cram%0d", i), dut.cram[i], 6'(i + 1));
        chk("addr_after_cram", dut.addr, 14'd7);

        bus_write(16'h00BF, 8'h20);
        bus_write(16'h00BF, 8'h81);
        chk("reg1", dut.regs[1], 8'h20);

        // Align to line 0, clear any pending vblank, then catch the next set.
        for (int k = 0; k < 400 && dut.line_cnt != 0; k++) @(negedge sysclk);
        bus_read(16'h00BF, rdata);
        chk("int_released_by_clear", ebus_int_n, 1'b1);
        wait_int_low();
        chk("int_asserted", ebus_int_n, 1'b0);
        chk("int_line", dut.line_cnt, 2);
        chk("int_pix", dut.pix_cnt, 0);

        bus_read(16'h00BF, rdata);
        chk("status_vblank", rdata, 8'h80);
        chk("int_after_status", ebus_int_n, 1'b1);
        bus_read(16'h00BF, rdata);
        chk("status_cleared", rdata, 8'h00);

        // Disabling the interrupt releases the line but keeps vblank.
        wait_int_low();
        chk("int_asserted2", ebus_int_n, 1'b0);
        bus_write(16'h00BF, 8'h00);
        bus_write(16'h00BF, 8'h81);
        chk("int_released_by_reg1", ebus_int_n, 1'b1);
        chk("vblank_kept", dut.vblank, 1'b1);

        // Address wrap at 14 bits
        bus_write(16'h00BF, 8'hFF);
        bus_write(16'h00BF, 8'h7F);
        bus_write(16'h00BE, 8'hAA);
        bus_write(16'h00BE, 8'h55);
        bus_write(16'h00BE, 8'h3C);
        chk("vram_3fff", dut.vram[16383], 8'hAA);
        chk("vram_0000", dut.vram[0], 8'h55);
        chk("addr_after_wrap", dut.addr, 14'd2);

        // Prefetch then two data reads
        bus_write(16'h00BF, 8'h00);
        bus_write(16'h00BF, 8'h00);
        bus_read(16'h00BE, rdata);
        chk("data_read0", rdata, 8'h55);
        bus_read(16'h00BE, rdata);
        chk("data_read1", rdata, 8'h3C);
        chk("addr_after_reads", dut.addr, 14'd3);

        ebus_busack_n = 1'b0;
        bus_write(16'h00BE, 8'h99);
        ebus_busack_n = 1'b1;
        chk("busack_ignored", dut.addr, 14'd3);

        // Status read resets the first-byte latch
        bus_write(16'h00BF, 8'h05);
        bus_read(16'h00BF, rdata);
        bus_write(16'h00BF, 8'h12);
        bus_write(16'h00BF, 8'h40);
        chk("latch_reset_addr", dut.addr, 14'h0012);
        chk("latch_reset_code", dut.code, 2'b01);

        // Reset with a half-written control word
        bus_write(16'h00BF, 8'h33);
        ebus_reset_n = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("midreset_phi", ebus_phi, 1'b0);
        chk("midreset_reg1", dut.regs[1], 8'h00);
        ebus_reset_n = 1'b1;
        bus_write(16'h00BF, 8'h44);
        bus_write(16'h00BF, 8'h40);
        chk("midreset_addr", dut.addr, 14'h0044);
        chk("midreset_code", dut.code, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
